// File: rtl/sk_coeff_streamer.sv
// Captures the decoded secret polynomials on start and streams their coefficients, reduced mod q,
// one per valid/ready handshake, with polynomial/coefficient tags and a sticky range flag.
module sk_coeff_streamer #(
  parameter int unsigned KYBER_N       = 256,
  parameter int unsigned KYBER_K       = 3,
  parameter int unsigned KYBER_R_WIDTH = 12,
  parameter int unsigned KYBER_Q       = 3329
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [KYBER_N*KYBER_R_WIDTH*KYBER_K-1:0] s_in,
  output logic [KYBER_R_WIDTH-1:0]                 coeff_out,
  output logic                                     coeff_valid,
  input  logic                                     coeff_ready,
  output logic [1:0]                               poly_idx,
  output logic [7:0]                               coeff_idx,
  output logic                                     last,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     range_err
);

  localparam int unsigned CapWidth = KYBER_N * KYBER_R_WIDTH * KYBER_K;
  localparam logic [KYBER_R_WIDTH-1:0] Q = KYBER_R_WIDTH'(KYBER_Q);
  localparam logic [1:0] LastPoly = 2'(KYBER_K - 1);
  localparam logic [7:0] LastIdx  = 8'(KYBER_N - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFin} state_e;

  state_e                   state_q, state_d;
  logic [CapWidth-1:0]      cap_q, cap_d;
  logic [KYBER_R_WIDTH-1:0] coeff_q, coeff_d;
  logic                     valid_q, valid_d;
  logic [1:0]               poly_q, poly_d;
  logic [7:0]               idx_q, idx_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [KYBER_R_WIDTH-1:0] raw;
  logic                     hs;

  // Raw values never reach 2q, so one conditional subtraction is a full reduction.
  function automatic logic [KYBER_R_WIDTH-1:0] reduce(input logic [KYBER_R_WIDTH-1:0] r);
    return (r >= Q) ? (r - Q) : r;
  endfunction

  assign hs = valid_q && coeff_ready;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    coeff_d = coeff_q;
    valid_d = valid_q;
    poly_d  = poly_q;
    idx_d   = idx_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    raw     = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // The capture register is used as a shift register; element (0,0) goes straight out.
          raw     = s_in[KYBER_R_WIDTH-1:0];
          cap_d   = s_in >> KYBER_R_WIDTH;
          coeff_d = reduce(raw);
          valid_d = 1'b1;
          poly_d  = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          err_d   = (raw >= Q);
          state_d = StStream;
        end
      end
      StStream: begin
        if (hs) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            raw     = cap_q[KYBER_R_WIDTH-1:0];
            cap_d   = cap_q >> KYBER_R_WIDTH;
            coeff_d = reduce(raw);
            if (idx_q == LastIdx) begin
              idx_d  = '0;
              poly_d = poly_q + 2'd1;
            end else begin
              idx_d  = idx_q + 8'd1;
            end
            last_d  = (poly_d == LastPoly) && (idx_d == LastIdx);
            err_d   = err_q | (raw >= Q);
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      coeff_q <= '0;
      valid_q <= 1'b0;
      poly_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coeff_q <= coeff_d;
      valid_q <= valid_d;
      poly_q  <= poly_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Capture contents are meaningless out of reset, so they carry no reset.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign coeff_out   = coeff_q;
  assign coeff_valid = valid_q;
  assign poly_idx    = poly_q;
  assign coeff_idx   = idx_q;
  assign last        = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign range_err   = err_q;

endmodule
